// File: rtl/exc_pkg.sv
// Shared types and constants for the nestable exception controller.
// Stack entries are sized for the widest datapath and truncated by the top.
package exc_pkg;

    localparam int unsigned EXC_XLEN  = 64;
    localparam int unsigned EXC_ESR_W = 8;

    typedef struct packed {
        logic [EXC_XLEN-1:0]  elr;
        logic [EXC_XLEN-1:0]  err;
        logic [EXC_ESR_W-1:0] esr;
    } exc_entry_t;

    localparam logic [1:0] EDS_ELR = 2'b00;
    localparam logic [1:0] EDS_ESR = 2'b01;
    localparam logic [1:0] EDS_ERR = 2'b10;
    localparam logic [1:0] EDS_LVL = 2'b11;

    localparam logic [EXC_XLEN-1:0] EXC_VBASE   = 64'hD8;
    localparam logic [EXC_XLEN-1:0] EXC_VSTRIDE = 64'h20;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module exc_prio_enc #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan high to low so the lowest set bit is the last assignment.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Multi-source, nestable exception controller: prioritises requests, vectors each source
// to its own handler and keeps a stack of return state so handlers can be preempted.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned   N       = 64,
    parameter int unsigned   NSRC    = 4,
    parameter int unsigned   DEPTH   = 2,
    parameter logic [N-1:0]  VBASE   = N'(EXC_VBASE),
    parameter logic [N-1:0]  VSTRIDE = N'(EXC_VSTRIDE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NSRC-1:0]              Exc,
    input  logic [3:0]                   EStatus,
    input  logic                         ERet,
    input  logic [N-1:0]                 NextPC,
    input  logic [N-1:0]                 imem_addr,
    input  logic [N-1:0]                 ALUBranch,
    input  logic [1:0]                   EDataSel,
    output logic                         EProc,
    output logic [N-1:0]                 EVAddr,
    output logic [N-1:0]                 PCBranch,
    output logic [N-1:0]                 readData,
    output logic [NSRC-1:0]              ExcAck,
    output logic [$clog2(DEPTH+1)-1:0]   Level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    exc_entry_t stack [DEPTH];
    exc_entry_t top;
    exc_entry_t new_entry;

    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] top_src;
    logic          level_zero;
    logic          take;
    logic          pop;

    // A source is masked during its own ack cycle so a slow deassert is not retaken.
    exc_prio_enc #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_prio_enc (
        .req   (Exc & ~ExcAck),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Level == LW'(i + 1)) top = stack[i];
        end
    end

    assign top_src    = top.esr[4 +: IW];
    assign level_zero = (Level == '0);
    assign take       = win_valid && (Level < LW'(DEPTH)) && (level_zero || (win_idx < top_src));
    assign pop        = ERet && !level_zero && !take;

    assign EProc    = take;
    assign EVAddr   = take ? (VBASE + N'(win_idx) * VSTRIDE) : '0;
    assign PCBranch = pop ? N'(top.elr) : ALUBranch;

    always_comb begin
        new_entry     = '0;
        new_entry.err = EXC_XLEN'(imem_addr);
        // A colliding ERET must re-execute once this handler returns.
        new_entry.elr = ERet ? EXC_XLEN'(imem_addr) : EXC_XLEN'(NextPC);
        new_entry.esr = EXC_ESR_W'({win_idx, EStatus});
    end

    always_comb begin
        readData = '0;
        case (EDataSel)
            EDS_ELR: readData = level_zero ? '0 : N'(top.elr);
            EDS_ESR: readData = level_zero ? '0 : N'(top.esr);
            EDS_ERR: readData = level_zero ? '0 : N'(top.err);
            EDS_LVL: readData = N'(Level);
            default: readData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Level  <= '0;
            ExcAck <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            ExcAck <= take ? (NSRC'(1) << win_idx) : '0;
            if (take) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (Level == LW'(i)) stack[i] <= new_entry;
                end
                Level <= Level + LW'(1);
            end else if (pop) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (Level == LW'(i + 1)) stack[i] <= '0;
                end
                Level <= Level - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl (NSRC=4, DEPTH=2) with hand-computed expectations.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Exc;
    logic [3:0]  EStatus;
    logic        ERet;
    logic [63:0] NextPC;
    logic [63:0] imem_addr;
    logic [63:0] ALUBranch;
    logic [1:0]  EDataSel;
    logic        EProc;
    logic [63:0] EVAddr;
    logic [63:0] PCBranch;
    logic [63:0] readData;
    logic [3:0]  ExcAck;
    logic [1:0]  Level;

    int tests = 0;
    int fails = 0;

    exception_ctrl #(
        .N     (64),
        .NSRC  (4),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Exc       (Exc),
        .EStatus   (EStatus),
        .ERet      (ERet),
        .NextPC    (NextPC),
        .imem_addr (imem_addr),
        .ALUBranch (ALUBranch),
        .EDataSel  (EDataSel),
        .EProc     (EProc),
        .EVAddr    (EVAddr),
        .PCBranch  (PCBranch),
        .readData  (readData),
        .ExcAck    (ExcAck),
        .Level     (Level)
    );

    always #10 clk = ~clk;

    // Leaves time 1 unit after a rising edge; inputs change here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Exc = '0; EStatus = '0; ERet = 1'b0; NextPC = '0;
        imem_addr = '0; ALUBranch = 64'h80; EDataSel = 2'b00;
        tick(); tick();
        reset = 1'b0;
        #1;
        tests++; if (Level !== 2'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", Level); end
        tests++; if (ExcAck !== 4'b0) begin fails++; $display("FAIL reset_ack got %b exp 0000", ExcAck); end
        tests++; if (EProc !== 1'b0) begin fails++; $display("FAIL reset_eproc got %b exp 0", EProc); end
        tests++; if (EVAddr !== 64'h0) begin fails++; $display("FAIL reset_evaddr got %h exp 0", EVAddr); end
        tests++; if (PCBranch !== 64'h80) begin fails++; $display("FAIL reset_pcbranch got %h exp 80", PCBranch); end
        for (int s = 0; s < 4; s++) begin
            EDataSel = 2'(s);
            #1;
            tests++;
            if (readData !== 64'h0) begin
                fails++; $display("FAIL reset_readdata sel %0d got %h exp 0", s, readData);
            end
        end
    endtask

    task automatic test_take_capture();
        logic [63:0] exp_rd [4];
        exp_rd[0] = 64'h44; exp_rd[1] = 64'h23; exp_rd[2] = 64'h40; exp_rd[3] = 64'h1;
        tick();
        Exc = 4'b0100; imem_addr = 64'h40; NextPC = 64'h44; EStatus = 4'd3;
        #1;
        tests++; if (EProc !== 1'b1) begin fails++; $display("FAIL take_eproc got %b exp 1", EProc); end
        tests++; if (EVAddr !== 64'h118) begin fails++; $display("FAIL take_evaddr got %h exp 118", EVAddr); end
        tick();
        Exc = '0;
        #1;
        tests++; if (ExcAck !== 4'b0100) begin fails++; $display("FAIL take_ack got %b exp 0100", ExcAck); end
        tests++; if (Level !== 2'd1) begin fails++; $display("FAIL take_level got %0d exp 1", Level); end
        for (int s = 0; s < 4; s++) begin
            EDataSel = 2'(s);
            #1;
            tests++;
            if (readData !== exp_rd[s]) begin
                fails++; $display("FAIL take_readdata sel %0d got %h exp %h", s, readData, exp_rd[s]);
            end
        end
        tick();
        #1;
        tests++; if (ExcAck !== 4'b0) begin fails++; $display("FAIL take_ack_drop got %b exp 0000", ExcAck); end
    endtask

    // Starts at Level=1 servicing src2 (ELR 0x44).
    task automatic test_preempt_block();
        Exc = 4'b0001; imem_addr = 64'h50; NextPC = 64'h54; EStatus = 4'd5;
        #1;
        tests++; if (EProc !== 1'b1) begin fails++; $display("FAIL preempt_eproc got %b exp 1", EProc); end
        tests++; if (EVAddr !== 64'hD8) begin fails++; $display("FAIL preempt_evaddr got %h exp d8", EVAddr); end
        tick();
        Exc = '0; EDataSel = 2'b01;
        #1;
        tests++; if (Level !== 2'd2) begin fails++; $display("FAIL preempt_level got %0d exp 2", Level); end
        tests++; if (readData !== 64'h05) begin fails++; $display("FAIL preempt_esr got %h exp 05", readData); end
        tests++; if (ExcAck !== 4'b0001) begin fails++; $display("FAIL preempt_ack got %b exp 0001", ExcAck); end
        ERet = 1'b1;
        #1;
        tests++; if (PCBranch !== 64'h54) begin fails++; $display("FAIL preempt_eret_pc got %h exp 54", PCBranch); end
        tick();
        ERet = 1'b0; Exc = 4'b1000;
        #1;
        tests++; if (Level !== 2'd1) begin fails++; $display("FAIL block_level got %0d exp 1", Level); end
        tests++; if (EProc !== 1'b0) begin fails++; $display("FAIL block_eproc got %b exp 0", EProc); end
        tick();
        #1;
        tests++; if (ExcAck !== 4'b0) begin fails++; $display("FAIL block_ack got %b exp 0000", ExcAck); end
        ERet = 1'b1;
        #1;
        tests++; if (EProc !== 1'b0) begin fails++; $display("FAIL block_eret_eproc got %b exp 0", EProc); end
        tests++; if (PCBranch !== 64'h44) begin fails++; $display("FAIL eret_pc got %h exp 44", PCBranch); end
        tick();
        ERet = 1'b0;
        #1;
        tests++; if (Level !== 2'd0) begin fails++; $display("FAIL eret_level got %0d exp 0", Level); end
        tests++; if (EProc !== 1'b1) begin fails++; $display("FAIL unblock_eproc got %b exp 1", EProc); end
        tests++; if (EVAddr !== 64'h138) begin fails++; $display("FAIL unblock_evaddr got %h exp 138", EVAddr); end
        tick();
        Exc = '0;
        #1;
        tests++; if (ExcAck !== 4'b1000) begin fails++; $display("FAIL unblock_ack got %b exp 1000", ExcAck); end
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
        #1;
        tests++; if (Level !== 2'd0) begin fails++; $display("FAIL unblock_ret_level got %0d exp 0", Level); end
        ERet = 1'b1; ALUBranch = 64'h80;
        #1;
        tests++; if (PCBranch !== 64'h80) begin fails++; $display("FAIL eret_l0_pc got %h exp 80", PCBranch); end
        tick();
        ERet = 1'b0;
        #1;
        tests++; if (Level !== 2'd0) begin fails++; $display("FAIL eret_l0_level got %0d exp 0", Level); end
    endtask

    task automatic test_stack_full();
        Exc = 4'b0100; imem_addr = 64'h200; NextPC = 64'h204; EStatus = 4'd1;
        tick();
        Exc = 4'b0010; imem_addr = 64'h300; NextPC = 64'h304;
        #1;
        tests++; if (EProc !== 1'b1) begin fails++; $display("FAIL b2b_eproc got %b exp 1", EProc); end
        tick();
        Exc = 4'b0001;
        #1;
        tests++; if (Level !== 2'd2) begin fails++; $display("FAIL full_level got %0d exp 2", Level); end
        tests++; if (EProc !== 1'b0) begin fails++; $display("FAIL full_eproc got %b exp 0", EProc); end
        tick();
        ERet = 1'b1;
        #1;
        tests++; if (EProc !== 1'b0) begin fails++; $display("FAIL full_eret_eproc got %b exp 0", EProc); end
        tests++; if (PCBranch !== 64'h304) begin fails++; $display("FAIL full_eret_pc got %h exp 304", PCBranch); end
        tick();
        ERet = 1'b0;
        #1;
        tests++; if (Level !== 2'd1) begin fails++; $display("FAIL full_pop_level got %0d exp 1", Level); end
        tests++; if (EProc !== 1'b1) begin fails++; $display("FAIL full_retake_eproc got %b exp 1", EProc); end
        tick();
        Exc = '0;
        #1;
        tests++; if (ExcAck !== 4'b0001) begin fails++; $display("FAIL full_retake_ack got %b exp 0001", ExcAck); end
    endtask

    task automatic test_collision();
        reset = 1'b1;
        tick();
        reset = 1'b0; Exc = 4'b0100; imem_addr = 64'h40; NextPC = 64'h44;
        tick();
        Exc = '0;
        tick();
        Exc = 4'b0001; ERet = 1'b1; imem_addr = 64'h100; NextPC = 64'h104; ALUBranch = 64'h80;
        #1;
        tests++; if (EProc !== 1'b1) begin fails++; $display("FAIL coll_eproc got %b exp 1", EProc); end
        tests++; if (PCBranch !== 64'h80) begin fails++; $display("FAIL coll_pc got %h exp 80", PCBranch); end
        tick();
        Exc = '0; ERet = 1'b0; EDataSel = 2'b00;
        #1;
        tests++; if (Level !== 2'd2) begin fails++; $display("FAIL coll_level got %0d exp 2", Level); end
        tests++; if (readData !== 64'h100) begin fails++; $display("FAIL coll_elr got %h exp 100", readData); end
    endtask

    // Starts at Level=2 from the collision scenario.
    task automatic test_reset_mid();
        reset = 1'b1; Exc = 4'b0010;
        tick();
        reset = 1'b0;
        #1;
        tests++; if (Level !== 2'd0) begin fails++; $display("FAIL rmid_level got %0d exp 0", Level); end
        tests++; if (ExcAck !== 4'b0) begin fails++; $display("FAIL rmid_ack got %b exp 0000", ExcAck); end
        for (int s = 0; s < 4; s++) begin
            EDataSel = 2'(s);
            #1;
            tests++;
            if (readData !== 64'h0) begin
                fails++; $display("FAIL rmid_readdata sel %0d got %h exp 0", s, readData);
            end
        end
        tests++; if (EProc !== 1'b1) begin fails++; $display("FAIL rmid_eproc got %b exp 1", EProc); end
        tests++; if (EVAddr !== 64'hF8) begin fails++; $display("FAIL rmid_evaddr got %h exp f8", EVAddr); end
        tick();
        Exc = '0;
        #1;
        tests++; if (Level !== 2'd1) begin fails++; $display("FAIL rmid_take_level got %0d exp 1", Level); end
        tests++; if (ExcAck !== 4'b0010) begin fails++; $display("FAIL rmid_take_ack got %b exp 0010", ExcAck); end
    endtask

    initial begin
        test_reset();
        test_take_capture();
        test_preempt_block();
        test_stack_full();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
